// File: rtl/memory_pkg.sv
// Shared types and constants for the parametrised single-port RAM.
// Provides the clear-sequencer state encoding and the read-during-write mode selectors.
// No ports; imported by the RAM top, its clear controller and the bench.
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // READ_MODE selectors: behaviour of a read and a write to the same word on one edge
  localparam int READ_FIRST  = 0;  // read returns the word as it was before the edge
  localparam int WRITE_FIRST = 1;  // read returns the data being written

endpackage

// File: rtl/memory_module_param_if.sv
// Access bus of the parametrised RAM: request side (data/address/rE/wE) and response side.
// Response signals (dataOut, dataValid, busy, addrError) are all registered inside the RAM.
// master = requester (drives the request, samples the response); slave = the RAM.
interface memory_module_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);

  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] address;
  logic                  rE;
  logic                  wE;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataValid;
  logic                  busy;
  logic                  addrError;

  modport master (
    output data, address, rE, wE,
    input  dataOut, dataValid, busy, addrError
  );

  modport slave (
    input  data, address, rE, wE,
    output dataOut, dataValid, busy, addrError
  );

endinterface

// File: rtl/mem_clear_ctrl.sv
// Post-reset clear sequencer: walks a pointer over every word so the top writes INIT_VALUE there.
// Ports: i_clk, i_rst_n (async active-low) in; o_busy, o_clr_we, o_clr_addr out.
// Latency: busy is high for exactly DEPTH rising edges after reset release, then READY until reset.
module mem_clear_ctrl
  import memory_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_busy,
  output logic             o_clr_we,
  output logic [PTR_W-1:0] o_clr_addr
);

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          // The edge that clears the last word is also the edge that leaves CLEAR.
          if (r_ptr == PTR_W'(DEPTH - 1)) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        READY: begin
          r_state <= READY;
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_clr_we   = r_busy;   // busy coincides exactly with the CLEAR state
  assign o_clr_addr = r_ptr;

endmodule

// File: rtl/memory_module_param.sv
// Parametrised single-port synchronous RAM with registered read data, valid strobe and range check.
// Ports: clock, reset (async active-low); bus (slave modport): data/address/rE/wE in,
//   dataOut/dataValid/busy/addrError out. Read latency 1 edge; no backpressure, rE/wE ignored while busy.
module memory_module_param
  import memory_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DEPTH      = 32,
  parameter int                    READ_MODE  = READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  memory_module_param_if.slave bus
);

  localparam int                  PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_vld;
  logic                  r_addr_err;

  logic                  w_busy;
  logic                  w_clr_we;
  logic [PTR_W-1:0]      w_clr_addr;
  logic                  w_legal;
  logic                  w_ready;
  logic [PTR_W-1:0]      w_user_idx;
  logic                  w_user_we;
  logic                  w_user_re;
  logic                  w_mem_we;
  logic [PTR_W-1:0]      w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  mem_clear_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_clear (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // Extra MSB keeps the range check exact even when DEPTH == 2**ADDR_WIDTH.
  assign w_legal    = ({1'b0, bus.address} < LP_DEPTH);
  assign w_ready    = ~w_busy;
  assign w_user_idx = bus.address[PTR_W-1:0];
  assign w_user_we  = w_ready & bus.wE & w_legal;
  assign w_user_re  = w_ready & bus.rE & w_legal;

  // The clear sequencer owns the write port while busy; user requests are gated off then.
  assign w_mem_we    = w_clr_we | w_user_we;
  assign w_mem_idx   = w_clr_we ? w_clr_addr : w_user_idx;
  assign w_mem_wdata = w_clr_we ? INIT_VALUE : bus.data;

  // Storage has no reset; contents come from the clear sequence.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
      r_data_vld <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_data_vld <= w_user_re;
      r_addr_err <= w_ready & (bus.rE | bus.wE) & ~w_legal;
      if (w_user_re) begin
        // Same-word read+write: write-first forwards the incoming data around the array.
        if (READ_MODE == WRITE_FIRST && bus.wE) begin
          r_data_out <= bus.data;
        end else begin
          r_data_out <= r_mem[w_user_idx];
        end
      end
    end
  end

  assign bus.dataOut   = r_data_out;
  assign bus.dataValid = r_data_vld;
  assign bus.busy      = w_busy;
  assign bus.addrError = r_addr_err;

endmodule

// File: tb/tb_memory_module_param.sv
// Bench for memory_module_param: two instances share clock, reset and stimulus.
// dut0: 8-bit x 32 words, read-first, init 0x00. dut1: 16-bit x 64 words, write-first, init 0x5A5A.
// A reference memory per instance queues expected responses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_memory_module_param;
  import memory_pkg::*;

  localparam int          D0    = 32;
  localparam int          D1    = 64;
  localparam logic [15:0] INIT1 = 16'h5A5A;

  typedef struct {
    bit          err;
    logic [15:0] dat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #50 clock = ~clock;

  memory_module_param_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(6)) bus0 ();
  memory_module_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus1 ();

  memory_module_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(D0), .READ_MODE(READ_FIRST), .INIT_VALUE(8'h00)
  ) dut0 (.clock(clock), .reset(reset), .bus(bus0));

  memory_module_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(6), .DEPTH(D1), .READ_MODE(WRITE_FIRST), .INIT_VALUE(INIT1)
  ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  // Reference state
  logic [15:0] m0 [D0];
  logic [15:0] m1 [D1];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          n_edges = 0;   // rising edges since reset release
  logic [15:0] last [2];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // After a full clear every word holds the init value, whatever was written before.
  task automatic init_models();
    for (int i = 0; i < D0; i++) m0[i] = 16'h0000;
    for (int i = 0; i < D1; i++) m1[i] = INIT1;
    q0.delete();
    q1.delete();
  endtask

  // Effect of one request on the edge about to happen.
  task automatic apply(input bit re, input bit we, input int a, input logic [15:0] d);
    if (n_edges >= D0 && (re || we)) begin
      if (a >= D0) q0.push_back('{1'b1, 16'h0});
      else begin
        if (re) q0.push_back('{1'b0, m0[a]});          // old word
        if (we) m0[a] = {8'h00, d[7:0]};
      end
    end
    if (n_edges >= D1 && (re || we)) begin
      if (a >= D1) q1.push_back('{1'b1, 16'h0});
      else begin
        if (we) m1[a] = d;
        if (re) q1.push_back('{1'b0, m1[a]});          // new word
      end
    end
  endtask

  task automatic cycle(input bit re, input bit we, input int a, input logic [15:0] d);
    bus0.rE = re; bus0.wE = we; bus0.address = 6'(a); bus0.data = d[7:0];
    bus1.rE = re; bus1.wE = we; bus1.address = 6'(a); bus1.data = d;
    if (reset) apply(re, we, a, d);
    @(posedge clock);
    if (reset) n_edges++;
    #1;
  endtask

  task automatic do_reset(input int n);
    cycle(1'b0, 1'b0, 0, 16'h0);   // let the previous response reach the monitor
    reset = 1'b0;
    n_edges = 0;
    init_models();
    repeat (n) cycle(1'b0, 1'b0, 0, 16'h0);
    reset = 1'b1;
  endtask

  task automatic mon(input int k, input logic vld, input logic err, input logic [15:0] dout);
    exp_t e;
    int   qs;
    qs = (k == 0) ? q0.size() : q1.size();
    if (vld || err) begin
      chk(!(vld && err), $sformatf("dut%0d_vld_and_err", k), {vld, err}, 2'b00);
      chk(qs != 0, $sformatf("dut%0d_unexpected_output", k), {vld, err}, 2'b00);
      if (qs != 0) begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk(e.err == err, $sformatf("dut%0d_resp_kind(1=err)", k), err, e.err);
        if (!e.err) chk(dout == e.dat, $sformatf("dut%0d_read_data", k), dout, e.dat);
      end
      if (err) chk(dout == last[k], $sformatf("dut%0d_held_on_err", k), dout, last[k]);
      if (vld) last[k] = dout;
    end else begin
      chk(dout == last[k], $sformatf("dut%0d_held_idle", k), dout, last[k]);
    end
  endtask

  // Monitor: outputs were registered on the preceding rising edge.
  initial begin
    last[0] = '0;
    last[1] = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk(bus0.dataOut == 8'h00 && !bus0.dataValid && !bus0.addrError && bus0.busy,
            "dut0_reset_state", {bus0.dataOut, bus0.dataValid, bus0.addrError, bus0.busy}, 32'h0001);
        chk(bus1.dataOut == 16'h0 && !bus1.dataValid && !bus1.addrError && bus1.busy,
            "dut1_reset_state", {bus1.dataOut, bus1.dataValid, bus1.addrError, bus1.busy}, 32'h0001);
        last[0] = '0;
        last[1] = '0;
      end else begin
        chk(bus0.busy == (n_edges < D0), "dut0_busy", bus0.busy, (n_edges < D0));
        chk(bus1.busy == (n_edges < D1), "dut1_busy", bus1.busy, (n_edges < D1));
        mon(0, bus0.dataValid, bus0.addrError, {8'h00, bus0.dataOut});
        mon(1, bus1.dataValid, bus1.addrError, bus1.dataOut);
      end
    end
  end

  initial begin
    int a;
    init_models();
    repeat (3) cycle(1'b0, 1'b0, 0, 16'h0);
    reset = 1'b1;

    // Hold a read of word 0 straight through the clear sequence
    repeat (D1 + 2) cycle(1'b1, 1'b0, 0, 16'h0);
    cycle(1'b0, 1'b0, 0, 16'h0);

    // Write then read back
    cycle(1'b0, 1'b1, 3, 16'h00A5);
    cycle(1'b1, 1'b0, 3, 16'h0);
    cycle(1'b0, 1'b0, 3, 16'h0);

    // Same-word read+write
    cycle(1'b0, 1'b1, 7, 16'h0011);
    cycle(1'b1, 1'b1, 7, 16'h0022);
    cycle(1'b1, 1'b0, 7, 16'h0);
    cycle(1'b0, 1'b0, 7, 16'h0);

    // Out-of-range for dut0, legal for dut1; no aliasing onto word 8
    cycle(1'b0, 1'b1, 40, 16'h00FF);
    cycle(1'b0, 1'b0, 40, 16'h0);
    cycle(1'b1, 1'b0, 8, 16'h0);
    cycle(1'b1, 1'b0, 40, 16'h0);
    cycle(1'b1, 1'b1, 45, 16'h1234);
    cycle(1'b0, 1'b0, 45, 16'h0);

    // Top word of the deeper instance
    cycle(1'b0, 1'b1, 63, 16'hBEEF);
    cycle(1'b1, 1'b0, 63, 16'h0);
    cycle(1'b0, 1'b0, 63, 16'h0);

    // Random traffic, biased toward a few low words for same-word hits
    repeat (600) begin
      if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 63);
      else                           a = $urandom_range(0, 7);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
    end
    for (int i = 0; i < D1; i++) cycle(1'b1, 1'b0, i, 16'h0);

    // Reset in the middle of the clear sequence, then full sweep
    do_reset(2);
    repeat (10) cycle(1'b1, 1'b1, 3, 16'hFFFF);
    do_reset(3);
    repeat (D1) cycle(1'b0, 1'b1, 5, 16'hAAAA);   // ignored while busy
    for (int i = 0; i < D1; i++) cycle(1'b1, 1'b0, i, 16'h0);

    // Reset right after an access
    cycle(1'b0, 1'b1, 9, 16'h7777);
    do_reset(1);
    repeat (D1) cycle(1'b0, 1'b0, 0, 16'h0);
    cycle(1'b1, 1'b0, 9, 16'h0);

    repeat (2) cycle(1'b0, 1'b0, 0, 16'h0);
    chk(q0.size() == 0, "dut0_missing_responses", q0.size(), 0);
    chk(q1.size() == 0, "dut1_missing_responses", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
